// File: rtl/aes_pkg.sv
// Shared AES definitions: the round-type encoding used by the decipher
// controller and the round datapath, round counts per key length, the keylen
// encoding and the controller FSM state encoding.
package aes_pkg;

    localparam logic [1:0] INIT_ROUND  = 2'd0;
    localparam logic [1:0] MAIN_ROUND  = 2'd1;
    localparam logic [1:0] FINAL_ROUND = 2'd2;

    localparam int AES_128_NR = 10;
    localparam int AES_256_NR = 14;

    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_INIT  = 2'd1,
        CTRL_MAIN  = 2'd2,
        CTRL_FINAL = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/aes_decipher_ctrl.sv
// Sequencing controller for the AES decipher round datapath. Holds the 128-bit
// state register, steps one round per clock and presents the round type and
// key index for the external combinational round logic and key memory.
module aes_decipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR_128 = AES_128_NR,
    parameter int NR_256 = AES_256_NR
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [1:0]   round_type,
    output logic [3:0]   round_idx,
    output logic [127:0] round_state,
    input  logic [127:0] round_result,
    output logic         ready,
    output logic [127:0] result,
    output logic         result_valid
);

    localparam logic [3:0] NR_128_W = 4'(NR_128);
    localparam logic [3:0] NR_256_W = 4'(NR_256);

    ctrl_state_t  fsm_state;
    logic [127:0] state_reg;
    logic [3:0]   round_ctr;
    logic [3:0]   nr_reg;
    logic [3:0]   start_nr;

    // Round count selected by the key length presented with the start pulse.
    assign start_nr = (keylen == KEYLEN_256) ? NR_256_W : NR_128_W;

    // Round sequencing FSM; every round loads the datapath output into the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_state    <= CTRL_IDLE;
            state_reg    <= '0;
            round_ctr    <= '0;
            nr_reg       <= NR_128_W;
            ready        <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            case (fsm_state)
                CTRL_IDLE: begin
                    if (next) begin
                        state_reg    <= block;
                        nr_reg       <= start_nr;
                        round_ctr    <= start_nr;
                        ready        <= 1'b0;
                        result_valid <= 1'b0;
                        fsm_state    <= CTRL_INIT;
                    end
                end
                CTRL_INIT: begin
                    // round_ctr still equals nr_reg here; first main round uses Nr-1.
                    state_reg <= round_result;
                    round_ctr <= nr_reg - 4'd1;
                    fsm_state <= CTRL_MAIN;
                end
                CTRL_MAIN: begin
                    state_reg <= round_result;
                    // Stop decrementing at 1 so the counter never wraps.
                    if (round_ctr == 4'd1) begin
                        fsm_state <= CTRL_FINAL;
                    end else begin
                        round_ctr <= round_ctr - 4'd1;
                    end
                end
                CTRL_FINAL: begin
                    state_reg    <= round_result;
                    ready        <= 1'b1;
                    result_valid <= 1'b1;
                    fsm_state    <= CTRL_IDLE;
                end
                default: begin
                    fsm_state <= CTRL_IDLE;
                end
            endcase
        end
    end

    // Round type and key index decoded from the current FSM state and counter.
    always_comb begin
        round_type = INIT_ROUND;
        round_idx  = 4'd0;
        case (fsm_state)
            CTRL_INIT: begin
                round_type = INIT_ROUND;
                round_idx  = round_ctr;
            end
            CTRL_MAIN: begin
                round_type = MAIN_ROUND;
                round_idx  = round_ctr;
            end
            CTRL_FINAL: begin
                round_type = FINAL_ROUND;
                round_idx  = 4'd0;
            end
            default: begin
                round_type = INIT_ROUND;
                round_idx  = 4'd0;
            end
        endcase
    end

    assign round_state = state_reg;
    assign result      = state_reg;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Bench for aes_decipher_ctrl. Includes a behavioural AES inverse round and key
// schedule standing in for the external datapath and key memory, then checks
// FIPS-197 known answers, the round sequence and the start/reset corner cases.
module tb_aes_decipher_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         next = 1'b0;
    logic         keylen = 1'b0;
    logic [127:0] block = '0;
    logic [1:0]   round_type;
    logic [3:0]   round_idx;
    logic [127:0] round_state;
    logic [127:0] round_result;
    logic         ready;
    logic [127:0] result;
    logic         result_valid;

    logic         use256 = 1'b0;
    int           cmp_cnt = 0;
    int           err_cnt = 0;

    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] rk128    [16];
    logic [127:0] rk256    [16];
    logic [31:0]  w        [60];

    typedef struct {
        logic         kl;
        logic [127:0] blk;
        logic [127:0] exp;
        int           lat;
    } kat_t;

    typedef struct {
        logic [1:0] rt;
        logic [3:0] idx;
        logic       rdy;
    } seq_t;

    kat_t kats [2];
    seq_t seqs [12];

    always #5 clk = ~clk;

    aes_decipher_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .next         (next),
        .keylen       (keylen),
        .block        (block),
        .round_type   (round_type),
        .round_idx    (round_idx),
        .round_state  (round_state),
        .round_result (round_result),
        .ready        (ready),
        .result       (result),
        .result_valid (result_valid)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    // One decipher round as the external datapath performs it:
    // INIT = AddRoundKey, InvShiftRows, InvSubBytes
    // MAIN = AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes
    // FINAL = AddRoundKey
    function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [1:0] rt,
                                               input logic [127:0] key);
        logic [127:0] s;
        logic [127:0] o;
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        s = st ^ key;
        if (rt == FINAL_ROUND) return s;
        for (int i = 0; i < 16; i++) b[i] = s[127 - 8 * i -: 8];
        if (rt == MAIN_ROUND) begin
            for (int c = 0; c < 4; c++) begin
                t[4*c]   = gmul(b[4*c], 8'd14) ^ gmul(b[4*c+1], 8'd11) ^ gmul(b[4*c+2], 8'd13) ^ gmul(b[4*c+3], 8'd9);
                t[4*c+1] = gmul(b[4*c], 8'd9)  ^ gmul(b[4*c+1], 8'd14) ^ gmul(b[4*c+2], 8'd11) ^ gmul(b[4*c+3], 8'd13);
                t[4*c+2] = gmul(b[4*c], 8'd13) ^ gmul(b[4*c+1], 8'd9)  ^ gmul(b[4*c+2], 8'd14) ^ gmul(b[4*c+3], 8'd11);
                t[4*c+3] = gmul(b[4*c], 8'd11) ^ gmul(b[4*c+1], 8'd13) ^ gmul(b[4*c+2], 8'd9)  ^ gmul(b[4*c+3], 8'd14);
            end
            for (int i = 0; i < 16; i++) b[i] = t[i];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r + 4 * c] = b[r + 4 * ((c - r + 4) % 4)];
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = inv_sbox[t[i]];
        return o;
    endfunction

    always_comb begin
        round_result = inv_round(round_state, round_type, use256 ? rk256[round_idx] : rk128[round_idx]);
    end

    task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Pulses next for one edge; returns at the falling edge after edge 0.
    task automatic start(input logic kl, input logic [127:0] blk);
        @(negedge clk);
        use256 = kl;
        keylen = kl;
        block  = blk;
        next   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        next = 1'b0;
    endtask

    // Counts edges until ready, bounded so a stuck controller cannot hang the run.
    task automatic wait_ready(output int k);
        k = 0;
        while (!ready && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_kat(input int i);
        int k;
        start(kats[i].kl, kats[i].blk);
        check_i($sformatf("kat%0d_busy", i), int'(ready), 0);
        check_w($sformatf("kat%0d_loaded", i), result, kats[i].blk);
        wait_ready(k);
        check_i($sformatf("kat%0d_latency", i), k, kats[i].lat);
        check_w($sformatf("kat%0d_result", i), result, kats[i].exp);
        check_i($sformatf("kat%0d_valid", i), int'(result_valid), 1);
    endtask

    initial begin
        int  k;
        logic busy_ok;

        // Reference S-boxes and both key schedules (keys 000102..0f and 000102..1f).
        for (int x = 0; x < 256; x++) begin
            logic [7:0] a;
            logic [7:0] s;
            a = ginv(8'(x));
            for (int j = 0; j < 8; j++)
                s[j] = a[j] ^ a[(j + 4) % 8] ^ a[(j + 5) % 8] ^ a[(j + 6) % 8] ^ a[(j + 7) % 8];
            s = s ^ 8'h63;
            sbox[x]     = s;
            inv_sbox[s] = 8'(x);
        end
        for (int r = 0; r < 16; r++) begin
            rk128[r] = '0;
            rk256[r] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            int          nk;
            int          nr;
            logic [7:0]  rc;
            logic [31:0] tmp;
            nk = (p == 0) ? 4 : 8;
            nr = (p == 0) ? 10 : 14;
            rc = 8'h01;
            for (int i = 0; i < 4 * (nr + 1); i++) begin
                if (i < nk) begin
                    w[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
                end else begin
                    tmp = w[i-1];
                    if (i % nk == 0) begin
                        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                        rc  = gmul(rc, 8'h02);
                    end else if (nk > 6 && i % nk == 4) begin
                        tmp = subword(tmp);
                    end
                    w[i] = w[i-nk] ^ tmp;
                end
            end
            for (int r = 0; r <= nr; r++) begin
                if (p == 0) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
                else        rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            end
        end

        kats[0] = '{kl: 1'b0, blk: CT_128, exp: PT, lat: 11};
        kats[1] = '{kl: 1'b1, blk: CT_256, exp: PT, lat: 15};

        seqs[0]  = '{rt: 2'd0, idx: 4'd10, rdy: 1'b0};
        seqs[1]  = '{rt: 2'd1, idx: 4'd9,  rdy: 1'b0};
        seqs[2]  = '{rt: 2'd1, idx: 4'd8,  rdy: 1'b0};
        seqs[3]  = '{rt: 2'd1, idx: 4'd7,  rdy: 1'b0};
        seqs[4]  = '{rt: 2'd1, idx: 4'd6,  rdy: 1'b0};
        seqs[5]  = '{rt: 2'd1, idx: 4'd5,  rdy: 1'b0};
        seqs[6]  = '{rt: 2'd1, idx: 4'd4,  rdy: 1'b0};
        seqs[7]  = '{rt: 2'd1, idx: 4'd3,  rdy: 1'b0};
        seqs[8]  = '{rt: 2'd1, idx: 4'd2,  rdy: 1'b0};
        seqs[9]  = '{rt: 2'd1, idx: 4'd1,  rdy: 1'b0};
        seqs[10] = '{rt: 2'd2, idx: 4'd0,  rdy: 1'b0};
        seqs[11] = '{rt: 2'd0, idx: 4'd0,  rdy: 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_i("rst_ready", int'(ready), 1);
        check_i("rst_valid", int'(result_valid), 0);
        check_w("rst_result", result, '0);
        check_i("rst_type", int'(round_type), 0);
        check_i("rst_idx", int'(round_idx), 0);
        reset_n = 1'b1;

        // Known-answer table
        for (int i = 0; i < 2; i++) run_kat(i);

        // Result holds while idle
        repeat (3) @(negedge clk);
        check_i("hold_valid", int'(result_valid), 1);
        check_w("hold_result", result, PT);

        // Per-cycle round type / key index / ready for AES-128
        start(1'b0, CT_128);
        for (int e = 0; e < 12; e++) begin
            if (e > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            check_i($sformatf("seq%0d", e), int'({round_type, round_idx, ready}),
                    int'({seqs[e].rt, seqs[e].idx, seqs[e].rdy}));
        end
        check_w("seq_result", result, PT);

        // next held high for 20 edges; block/keylen changed mid-run
        @(negedge clk);
        use256  = 1'b0;
        keylen  = 1'b0;
        block   = CT_128;
        next    = 1'b1;
        busy_ok = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 5) begin
                block  = CT_256;
                keylen = 1'b1;
            end
            if (e <= 10 && ready) busy_ok = 1'b0;
            if (e == 11) begin
                check_i("held_ready_rise", int'(ready), 1);
                check_w("held_first_result", result, PT);
                use256 = 1'b1;
            end
            if (e == 12) begin
                check_i("held_restart_busy", int'(ready), 0);
                check_i("held_restart_idx", int'(round_idx), 14);
                check_w("held_restart_block", result, CT_256);
            end
            if (e == 19) next = 1'b0;
        end
        check_i("held_no_early_start", int'(busy_ok), 1);
        wait_ready(k);
        check_i("held_second_latency", k, 7);
        check_w("held_second_result", result, PT);

        // Reset at edge 5 of an AES-256 run
        start(1'b1, CT_256);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_i("abort_ready", int'(ready), 1);
        check_i("abort_valid", int'(result_valid), 0);
        check_w("abort_result", result, '0);
        check_i("abort_idx", int'(round_idx), 0);
        run_kat(0);

        // Reset and next on the same edge: reset wins
        @(negedge clk);
        reset_n = 1'b0;
        next    = 1'b1;
        use256  = 1'b0;
        keylen  = 1'b0;
        block   = CT_128;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        next    = 1'b0;
        check_i("rstnext_ready", int'(ready), 1);
        check_i("rstnext_valid", int'(result_valid), 0);
        check_w("rstnext_result", result, '0);
        check_i("rstnext_idx", int'(round_idx), 0);
        repeat (3) @(negedge clk);
        check_i("rstnext_still_ready", int'(ready), 1);
        check_w("rstnext_still_zero", result, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
